// File: rtl/rr_encode_arbiter.sv
// rr_encode_arbiter: 8-way round-robin arbiter with a registered one-hot grant
// and its 3-bit encoded index (bit k -> index k).
// Optional grant-hold timeout is compiled in with `define ARB_TIMEOUT_EN.
module rr_encode_arbiter #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // One-hot decode of a 3-bit index.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'b0000_0001 << idx;
  endfunction

  state_t      state_r, state_n;
  logic [7:0]  gnt_r, gnt_n;
  logic [2:0]  idx_r, idx_n;
  logic        vld_r, vld_n;
  logic        to_r, to_n;
  logic [2:0]  ptr_r, ptr_n;
  logic        found_s;
  logic [2:0]  pick_s;
  logic [2:0]  cand_s;
  logic        rel_norm_s;
  logic        hold_lim_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_r, hold_n;
`endif

  // Search for the first requester at or after the priority pointer (wrapping).
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_r;
    cand_s  = ptr_r;
    for (int i = 0; i < 8; i++) begin
      cand_s = ptr_r + 3'(i);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Release causes other than the hold limit, and the hold-limit flag itself.
  always_comb begin
    rel_norm_s = done || !req[idx_r] || !en;
`ifdef ARB_TIMEOUT_EN
    hold_lim_s = (hold_r == HOLD_LIM);
`else
    hold_lim_s = 1'b0;
`endif
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_n = state_r;
    gnt_n   = gnt_r;
    idx_n   = idx_r;
    vld_n   = vld_r;
    to_n    = 1'b0;
    ptr_n   = ptr_r;
`ifdef ARB_TIMEOUT_EN
    hold_n  = hold_r;
`endif
    case (state_r)
      IDLE: begin
        gnt_n = 8'h00;
        vld_n = 1'b0;
        if (en && found_s) begin
          gnt_n   = onehot8(pick_s);
          idx_n   = pick_s;
          vld_n   = 1'b1;
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (rel_norm_s || hold_lim_s) begin
          gnt_n   = 8'h00;
          vld_n   = 1'b0;
          ptr_n   = idx_r + 3'd1;
          state_n = IDLE;
          // A forced revoke is flagged only when nothing else released the grant.
          to_n    = hold_lim_s && !rel_norm_s;
        end else begin
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_n  = hold_r + HOLD_W'(1);
`endif
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 8'h00;
        vld_n   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= 8'h00;
      idx_r   <= 3'd0;
      vld_r   <= 1'b0;
      to_r    <= 1'b0;
      ptr_r   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      hold_r  <= '0;
`endif
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      idx_r   <= idx_n;
      vld_r   <= vld_n;
      to_r    <= to_n;
      ptr_r   <= ptr_n;
`ifdef ARB_TIMEOUT_EN
      hold_r  <= hold_n;
`endif
    end
  end

  assign gnt     = gnt_r;
  assign gnt_idx = idx_r;
  assign gnt_vld = vld_r;
  assign timeout = to_r;

endmodule

// File: tb/tb_rr_encode_arbiter.sv
// Directed testbench for rr_encode_arbiter with hand-computed expectations.
module tb_rr_encode_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_vec;
  int n_err;

`ifdef ARB_TIMEOUT_EN
  rr_encode_arbiter #(.MAX_HOLD(4)) dut (
`else
  rr_encode_arbiter dut (
`endif
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a grant to k after the next edge, then release it with done.
  task automatic grant_cycle(input logic [2:0] k, input string tag);
    logic [7:0] oh;
    oh = 8'h01 << k;
    tick();
    check({tag, "_idx"}, 32'(gnt_idx), 32'(k));
    check({tag, "_gnt"}, 32'(gnt), 32'(oh));
    check({tag, "_vld"}, 32'(gnt_vld), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check({tag, "_rel_vld"}, 32'(gnt_vld), 32'd0);
    check({tag, "_rel_gnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Two requesters alternate: 0,7,0,7.
    en = 1'b1; req = 8'h81;
    grant_cycle(3'd0, "alt0");
    grant_cycle(3'd7, "alt1");
    grant_cycle(3'd0, "alt2");
    grant_cycle(3'd7, "alt3");

    // All requesting: full rotation with wrap back to 0.
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      grant_cycle(3'(i % 8), "rot");
    end

    // Enable low blocks grants; raising it grants requester 4.
    en = 1'b0; req = 8'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en0_vld", 32'(gnt_vld), 32'd0);
    end
    en = 1'b1;
    tick();
    check("en1_gnt", 32'(gnt), 32'h10);
    check("en1_idx", 32'(gnt_idx), 32'd4);
    done = 1'b1;
    tick();
    done = 1'b0;

    // Request drop releases; other lines toggling do not disturb the grant.
    rst = 1'b1; req = 8'h00;
    tick();
    rst = 1'b0;
    req = 8'h24;
    tick();
    check("drop_idx2", 32'(gnt_idx), 32'd2);
    req = 8'h64;
    tick();
    check("tog_idx", 32'(gnt_idx), 32'd2);
    check("tog_gnt", 32'(gnt), 32'h04);
    req = 8'h24;
    tick();
    check("tog2_gnt", 32'(gnt), 32'h04);
    req = 8'h20;
    tick();
    check("drop_gnt0", 32'(gnt), 32'd0);
    check("drop_vld0", 32'(gnt_vld), 32'd0);
    tick();
    check("drop_idx5", 32'(gnt_idx), 32'd5);
    check("drop_gnt5", 32'(gnt), 32'h20);
    done = 1'b1;
    tick();
    done = 1'b0;

    // Reset during a grant to 6, then 8'hC1 goes to requester 0.
    req = 8'h40;
    tick();
    check("mid_idx6", 32'(gnt_idx), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_vld", 32'(gnt_vld), 32'd0);
    check("mid_rst_idx", 32'(gnt_idx), 32'd0);
    req = 8'hC1;
    tick();
    check("post_rst_idx", 32'(gnt_idx), 32'd0);
    check("post_rst_gnt", 32'(gnt), 32'h01);
    done = 1'b1;
    tick();
    done = 1'b0;

    // Long hold on requester 1 with no done.
    req = 8'h02;
    tick();
    check("hold_c1_idx", 32'(gnt_idx), 32'd1);
    check("hold_c1_vld", 32'(gnt_vld), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("hold_vld", 32'(gnt_vld), 32'd1);
      check("hold_to", 32'(timeout), 32'd0);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    check("to_vld", 32'(gnt_vld), 32'd0);
    check("to_pulse", 32'(timeout), 32'd1);
    tick();
    check("to_regrant_idx", 32'(gnt_idx), 32'd1);
    check("to_regrant_vld", 32'(gnt_vld), 32'd1);
    check("to_clear", 32'(timeout), 32'd0);
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("to_done_vld", 32'(gnt_vld), 32'd0);
    check("to_done_pulse", 32'(timeout), 32'd0);
`else
    check("nto_vld", 32'(gnt_vld), 32'd1);
    check("nto_to", 32'(timeout), 32'd0);
    tick();
    check("nto_vld2", 32'(gnt_vld), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("nto_rel", 32'(gnt_vld), 32'd0);
`endif

    // done in IDLE is ignored.
    req = 8'h00; done = 1'b1;
    tick();
    done = 1'b0;
    check("idle_done_vld", 32'(gnt_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
